axil_slave_regbank: RTL and testbench

- AXI4-Lite responder (slave) exposing a bank of 32-bit read/write control registers.
- It is the other end of the link driven by the team's AXI4-Lite master IP, and replaces the slave VIP in system builds.
- It presents the register contents and per-register write pulses to user logic.
- It returns SLVERR for accesses outside the implemented range.

---
 rtl/axil_slave_regbank.sv | 149 ++++++++++++++
 tb/tb_axil_slave_regbank.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_slave_regbank.sv
// AXI4-Lite register bank: NUM_REGS x 32-bit R/W registers with per-register write pulses.
// Optional AXIL_SLV_RO_ID_EN turns register 0 into a read-only ID word.
module axil_slave_regbank #(
  parameter int          NUM_REGS  = 8,
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [ADDR_W-1:0]      S_AXI_AWADDR,
  input  logic [2:0]             S_AXI_AWPROT,
  input  logic                   S_AXI_AWVALID,
  output logic                   S_AXI_AWREADY,
  input  logic [31:0]            S_AXI_WDATA,
  input  logic [3:0]             S_AXI_WSTRB,
  input  logic                   S_AXI_WVALID,
  output logic                   S_AXI_WREADY,
  output logic [1:0]             S_AXI_BRESP,
  output logic                   S_AXI_BVALID,
  input  logic                   S_AXI_BREADY,
  input  logic [ADDR_W-1:0]      S_AXI_ARADDR,
  input  logic [2:0]             S_AXI_ARPROT,
  input  logic                   S_AXI_ARVALID,
  output logic                   S_AXI_ARREADY,
  output logic [31:0]            S_AXI_RDATA,
  output logic [1:0]             S_AXI_RRESP,
  output logic                   S_AXI_RVALID,
  input  logic                   S_AXI_RREADY,
  output logic [NUM_REGS*32-1:0] REG_OUT,
  output logic [NUM_REGS-1:0]    WR_PULSE
);
  localparam int          IDX_W  = ADDR_W - 2;
  localparam logic [31:0] ID_VAL = 32'h4158_4C53;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t          wstate;
  rstate_t          rstate;
  logic [31:0]      regs    [NUM_REGS];
  logic [31:0]      rd_word [NUM_REGS];
  logic [IDX_W-1:0] aw_idx_q, c_idx, ar_idx;
  logic [31:0]      wdata_q, c_data, rd_sel;
  logic [3:0]       wstrb_q, c_strb;
  logic [NUM_REGS-1:0] c_onehot;
  logic aw_hs, w_hs, ar_hs, commit, wr_ok, ar_in_range;
  logic unused;

  assign unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = ~ARESET & (wstate == W_IDLE || wstate == W_HAVE_W);
  assign S_AXI_WREADY  = ~ARESET & (wstate == W_IDLE || wstate == W_HAVE_AW);
  assign S_AXI_ARREADY = ~ARESET & (rstate == R_IDLE);
  assign S_AXI_BVALID  = (wstate == W_RESP);
  assign S_AXI_RVALID  = (rstate == R_DATA);

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  // A payload handshaking this cycle is used directly so commit needs no extra cycle.
  assign commit = (aw_hs | (wstate == W_HAVE_AW)) & (w_hs | (wstate == W_HAVE_W));
  assign c_idx  = aw_hs ? S_AXI_AWADDR[ADDR_W-1:2] : aw_idx_q;
  assign c_data = w_hs ? S_AXI_WDATA : wdata_q;
  assign c_strb = w_hs ? S_AXI_WSTRB : wstrb_q;
  assign ar_idx = S_AXI_ARADDR[ADDR_W-1:2];
  assign ar_in_range = 32'(ar_idx) < NUM_REGS;

`ifdef AXIL_SLV_RO_ID_EN
  assign wr_ok = (32'(c_idx) < NUM_REGS) && (c_idx != '0);
`else
  assign wr_ok = (32'(c_idx) < NUM_REGS);
`endif

  always_comb begin
    REG_OUT  = '0;
    rd_sel   = '0;
    c_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_word[i] = regs[i];
`ifdef AXIL_SLV_RO_ID_EN
      if (i == 0) rd_word[i] = ID_VAL;
`endif
      REG_OUT[32*i +: 32] = rd_word[i];
      if (ar_idx == IDX_W'(i)) rd_sel = rd_word[i];
      if (c_idx == IDX_W'(i)) c_onehot[i] = 1'b1;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else if (commit && wr_ok) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (c_onehot[i])
          for (int b = 0; b < 4; b++)
            if (c_strb[b]) regs[i][8*b +: 8] <= c_data[8*b +: 8];
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wstate      <= W_IDLE;
      aw_idx_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      S_AXI_BRESP <= 2'b00;
      WR_PULSE    <= '0;
    end else begin
      WR_PULSE <= '0;
      if (aw_hs) aw_idx_q <= S_AXI_AWADDR[ADDR_W-1:2];
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (commit) begin
        wstate      <= W_RESP;
        S_AXI_BRESP <= wr_ok ? 2'b00 : 2'b10;
        WR_PULSE    <= wr_ok ? c_onehot : '0;
      end else begin
        case (wstate)
          W_IDLE:  if (aw_hs) wstate <= W_HAVE_AW;
                   else if (w_hs) wstate <= W_HAVE_W;
          W_RESP:  if (S_AXI_BREADY) wstate <= W_IDLE;
          default: ;
        endcase
      end
    end
  end

  // Read data is captured from pre-edge register values, so a same-edge write returns old data.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rstate      <= R_IDLE;
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= 2'b00;
    end else begin
      case (rstate)
        R_IDLE: if (ar_hs) begin
          rstate      <= R_DATA;
          S_AXI_RDATA <= ar_in_range ? rd_sel : 32'h0;
          S_AXI_RRESP <= ar_in_range ? 2'b00 : 2'b10;
        end
        R_DATA: if (S_AXI_RREADY) rstate <= R_IDLE;
        default: rstate <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axil_slave_regbank.sv
// Directed self-checking bench for axil_slave_regbank (NUM_REGS=8, ADDR_W=8).
module tb_axil_slave_regbank;
  localparam int NR = 8;
  localparam int AW = 8;
  localparam logic [31:0] ID_VAL = 32'h4158_4C53;

  logic clk = 1'b0, rst = 1'b1;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [2:0] awprot = '0, arprot = '0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [31:0] wdata = '0, rdata;
  logic [3:0] wstrb = '0;
  logic [1:0] bresp, rresp;
  logic [NR*32-1:0] reg_out;
  logic [NR-1:0] wr_pulse;

  int chk_cnt = 0, pass_cnt = 0;
  logic [31:0] exp_regs [NR];

  axil_slave_regbank #(.NUM_REGS(NR), .ADDR_W(AW), .RESET_VAL(32'h0)) dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .REG_OUT(reg_out), .WR_PULSE(wr_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [NR*32-1:0] exp_flat();
    logic [NR*32-1:0] f;
    for (int i = 0; i < NR; i++) f[32*i +: 32] = exp_regs[i];
`ifdef AXIL_SLV_RO_ID_EN
    f[31:0] = ID_VAL;
`endif
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, output logic bv, output logic [1:0] br,
                          output logic [NR-1:0] pl, output logic [NR-1:0] early);
    bit aw_done = 0, w_done = 0, awf, wf;
    int c = 0;
    early = '0;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && c < 40) begin
      awvalid = !aw_done && c >= aw_dly;
      wvalid  = !w_done && c >= w_dly;
      awf = awvalid && awready;
      wf  = wvalid && wready;
      tick();
      aw_done |= awf;
      w_done  |= wf;
      if (!(aw_done && w_done)) early |= wr_pulse;
      c++;
    end
    awvalid = 0; wvalid = 0;
    bv = bvalid; br = bresp; pl = wr_pulse;
  endtask

  task automatic do_bresp(output logic bv_after, output logic [NR-1:0] pl_after);
    bready = 1;
    tick();
    bready = 0;
    bv_after = bvalid;
    pl_after = wr_pulse;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic rv, output logic [31:0] d,
                         output logic [1:0] r);
    bit fired = 0;
    int c = 0;
    araddr = a;
    arvalid = 1;
    while (!fired && c < 20) begin
      fired = arready;
      tick();
      c++;
    end
    arvalid = 0;
    rv = rvalid; d = rdata; r = rresp;
    rready = 1;
    tick();
    rready = 0;
  endtask

  task automatic test_reset();
    logic rv; logic [31:0] d; logic [1:0] r;
    rst = 1;
    repeat (20) tick();
    chk_cnt++; if ({awready, wready, arready} !== 3'b000) $display("FAIL rst_ready got=%b exp=000", {awready, wready, arready}); else pass_cnt++;
    rst = 0;
    for (int i = 0; i < NR; i++) exp_regs[i] = 32'h0;
    tick();
    chk_cnt++; if ({bvalid, rvalid} !== 2'b00) $display("FAIL rst_valid got=%b exp=00", {bvalid, rvalid}); else pass_cnt++;
    chk_cnt++; if (wr_pulse !== '0) $display("FAIL rst_pulse got=%h exp=0", wr_pulse); else pass_cnt++;
    chk_cnt++; if (reg_out !== exp_flat()) $display("FAIL rst_regout got=%h exp=%h", reg_out, exp_flat()); else pass_cnt++;
    do_read(8'h04, rv, d, r);
    chk_cnt++; if ({rv, d, r} !== {1'b1, 32'h0, 2'b00}) $display("FAIL rst_read got=%b/%h/%b exp=1/0/00", rv, d, r); else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    logic bv, rv; logic [1:0] br, r; logic [NR-1:0] pl, early; logic [31:0] d;
    do_write(8'h08, 32'hDEADBEEF, 4'hF, 0, 0, bv, br, pl, early);
    chk_cnt++; if ({bv, br} !== 3'b100) $display("FAIL same_b got=%b/%b exp=1/00", bv, br); else pass_cnt++;
    chk_cnt++; if (pl !== 8'b0000_0100 || early !== '0) $display("FAIL same_pulse got=%b early=%b exp=00000100", pl, early); else pass_cnt++;
    exp_regs[2] = 32'hDEADBEEF;
    chk_cnt++; if (reg_out !== exp_flat()) $display("FAIL same_regout got=%h exp=%h", reg_out, exp_flat()); else pass_cnt++;
    do_bresp(bv, pl);
    chk_cnt++; if ({bv, pl} !== 9'b0) $display("FAIL same_bclear got bv=%b pulse=%b exp=0/0", bv, pl); else pass_cnt++;
    do_read(8'h08, rv, d, r);
    chk_cnt++; if ({rv, d, r} !== {1'b1, 32'hDEADBEEF, 2'b00}) $display("FAIL same_read got=%b/%h/%b exp=1/deadbeef/00", rv, d, r); else pass_cnt++;
  endtask

  task automatic test_ordering();
    logic bv, rv; logic [1:0] br, r; logic [NR-1:0] pl, early; logic [31:0] d;
    do_write(8'h0C, 32'hDEADBEEF, 4'hF, 3, 0, bv, br, pl, early);
    chk_cnt++; if ({bv, br, pl, early} !== {3'b100, 8'b0000_1000, 8'h00}) $display("FAIL order_w_first got=%b/%b/%b/%b exp=1/00/00001000/0", bv, br, pl, early); else pass_cnt++;
    do_bresp(bv, pl);
    chk_cnt++; if (bv !== 1'b0) $display("FAIL order_b1_clear got=%b exp=0", bv); else pass_cnt++;
    do_write(8'h0C, 32'h11223344, 4'b0101, 0, 2, bv, br, pl, early);
    chk_cnt++; if ({bv, br, pl, early} !== {3'b100, 8'b0000_1000, 8'h00}) $display("FAIL order_aw_first got=%b/%b/%b/%b exp=1/00/00001000/0", bv, br, pl, early); else pass_cnt++;
    do_bresp(bv, pl);
    chk_cnt++; if (bv !== 1'b0) $display("FAIL order_b2_clear got=%b exp=0", bv); else pass_cnt++;
    exp_regs[3] = 32'hDE22BE44;
    chk_cnt++; if (reg_out !== exp_flat()) $display("FAIL order_regout got=%h exp=%h", reg_out, exp_flat()); else pass_cnt++;
    do_read(8'h0C, rv, d, r);
    chk_cnt++; if ({rv, d, r} !== {1'b1, 32'hDE22BE44, 2'b00}) $display("FAIL order_read got=%b/%h/%b exp=1/de22be44/00", rv, d, r); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic bv; logic [1:0] br; logic [NR-1:0] pl, early;
    bit stable = 1, ar_ok;
    do_write(8'h10, 32'hA5A5_0001, 4'hF, 0, 0, bv, br, pl, early);
    exp_regs[4] = 32'hA5A5_0001;
    repeat (5) begin
      tick();
      if (!(bvalid === 1'b1 && bresp === 2'b00 && awready === 1'b0 && wready === 1'b0 && wr_pulse === '0)) stable = 0;
    end
    chk_cnt++; if (stable !== 1'b1) $display("FAIL bp_write_hold got=0 exp=1 (bvalid=%b bresp=%b awready=%b wready=%b)", bvalid, bresp, awready, wready); else pass_cnt++;
    do_bresp(bv, pl);
    chk_cnt++; if (bv !== 1'b0) $display("FAIL bp_b_clear got=%b exp=0", bv); else pass_cnt++;
    araddr = 8'h10;
    arvalid = 1;
    ar_ok = arready;
    tick();
    arvalid = 0;
    chk_cnt++; if (ar_ok !== 1'b1) $display("FAIL bp_arready got=%b exp=1", ar_ok); else pass_cnt++;
    stable = 1;
    repeat (4) begin
      if (!(rvalid === 1'b1 && rdata === 32'hA5A5_0001 && rresp === 2'b00 && arready === 1'b0)) stable = 0;
      tick();
    end
    chk_cnt++; if (stable !== 1'b1) $display("FAIL bp_read_hold got=0 exp=1 (rvalid=%b rdata=%h arready=%b)", rvalid, rdata, arready); else pass_cnt++;
    rready = 1;
    tick();
    rready = 0;
    chk_cnt++; if (rvalid !== 1'b0) $display("FAIL bp_r_clear got=%b exp=0", rvalid); else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    logic bv, rv; logic [1:0] br, r; logic [NR-1:0] pl, early; logic [31:0] d;
    do_write(8'h20, 32'hFFFF_FFFF, 4'hF, 0, 0, bv, br, pl, early);
    chk_cnt++; if ({bv, br} !== 3'b110) $display("FAIL oor_b got=%b/%b exp=1/10", bv, br); else pass_cnt++;
    chk_cnt++; if ((pl | early) !== '0) $display("FAIL oor_pulse got=%b exp=0", pl | early); else pass_cnt++;
    chk_cnt++; if (reg_out !== exp_flat()) $display("FAIL oor_regout got=%h exp=%h", reg_out, exp_flat()); else pass_cnt++;
    do_bresp(bv, pl);
    do_read(8'hFC, rv, d, r);
    chk_cnt++; if ({rv, d, r} !== {1'b1, 32'h0, 2'b10}) $display("FAIL oor_read got=%b/%h/%b exp=1/0/10", rv, d, r); else pass_cnt++;
  endtask

  task automatic test_collision();
    logic rv; logic [1:0] r; logic [31:0] d;
    awaddr = 8'h08; wdata = 32'h5; wstrb = 4'hF; araddr = 8'h08;
    awvalid = 1; wvalid = 1; arvalid = 1;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk_cnt++; if ({bvalid, rvalid, wr_pulse} !== {2'b11, 8'b0000_0100}) $display("FAIL coll_valid got=%b%b/%b exp=11/00000100", bvalid, rvalid, wr_pulse); else pass_cnt++;
    chk_cnt++; if (rdata !== 32'hDEADBEEF) $display("FAIL coll_old got=%h exp=deadbeef", rdata); else pass_cnt++;
    bready = 1; rready = 1;
    tick();
    bready = 0; rready = 0;
    exp_regs[2] = 32'h5;
    do_read(8'h08, rv, d, r);
    chk_cnt++; if ({rv, d, r} !== {1'b1, 32'h5, 2'b00}) $display("FAIL coll_new got=%b/%h/%b exp=1/5/00", rv, d, r); else pass_cnt++;
  endtask

  task automatic test_reg0();
    logic bv, rv; logic [1:0] br, r; logic [NR-1:0] pl, early; logic [31:0] d;
`ifdef AXIL_SLV_RO_ID_EN
    do_read(8'h00, rv, d, r);
    chk_cnt++; if ({rv, d, r} !== {1'b1, ID_VAL, 2'b00}) $display("FAIL id_read got=%b/%h/%b exp=1/41584c53/00", rv, d, r); else pass_cnt++;
    do_write(8'h00, 32'hFFFF_FFFF, 4'hF, 0, 0, bv, br, pl, early);
    chk_cnt++; if ({bv, br, pl} !== {3'b110, 8'h00}) $display("FAIL id_write got=%b/%b/%b exp=1/10/0", bv, br, pl); else pass_cnt++;
    do_bresp(bv, pl);
    chk_cnt++; if (reg_out !== exp_flat()) $display("FAIL id_regout got=%h exp=%h", reg_out, exp_flat()); else pass_cnt++;
`else
    do_write(8'h00, 32'hCAFE_F00D, 4'hF, 0, 0, bv, br, pl, early);
    chk_cnt++; if ({bv, br, pl} !== {3'b100, 8'h01}) $display("FAIL r0_write got=%b/%b/%b exp=1/00/00000001", bv, br, pl); else pass_cnt++;
    do_bresp(bv, pl);
    exp_regs[0] = 32'hCAFE_F00D;
    do_read(8'h00, rv, d, r);
    chk_cnt++; if ({rv, d, r} !== {1'b1, 32'hCAFE_F00D, 2'b00}) $display("FAIL r0_read got=%b/%h/%b exp=1/cafef00d/00", rv, d, r); else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid();
    awaddr = 8'h14;
    awvalid = 1;
    tick();
    awvalid = 0;
    #2 rst = 1;
    #1;
    chk_cnt++; if ({awready, wready, arready} !== 3'b000) $display("FAIL mid_ready got=%b exp=000", {awready, wready, arready}); else pass_cnt++;
    repeat (2) tick();
    rst = 0;
    for (int i = 0; i < NR; i++) exp_regs[i] = 32'h0;
    wdata = 32'h77; wstrb = 4'hF;
    wvalid = 1;
    tick();
    wvalid = 0;
    tick();
    chk_cnt++; if ({bvalid, wr_pulse} !== 9'b0) $display("FAIL mid_drop got bvalid=%b pulse=%b exp=0/0", bvalid, wr_pulse); else pass_cnt++;
    chk_cnt++; if (reg_out !== exp_flat()) $display("FAIL mid_regout got=%h exp=%h", reg_out, exp_flat()); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_same_cycle();
    test_ordering();
    test_backpressure();
    test_out_of_range();
    test_collision();
    test_reg0();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
